// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: shares the single RAM port between icache and dcache.
// Define ARB_STATS_EN to add icnt/dcnt/ecnt completion and error counters.
module cache_mem_arbiter #(
  parameter int LOCK_MAX = 16
`ifdef ARB_STATS_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate
`ifdef ARB_STATS_EN
  , output logic [CNT_W-1:0] icnt,
  output logic [CNT_W-1:0] dcnt,
  output logic [CNT_W-1:0] ecnt
`endif
);

  localparam int HW = $clog2(LOCK_MAX + 1);

  typedef enum logic [1:0] {
    IDLE,
    IGNT,
    DGNT
  } state_t;

  state_t        state;
  logic          last_d;
  logic [HW-1:0] hold_cnt;

  logic ireq, dreq, acc;
  logic ion, don, icomp, dcomp;

  assign ireq  = iREN;
  assign dreq  = dREN | dWEN;
  assign acc   = (ramstate == 2'd2);
  // Reset gates the grant so the RAM enables fall in the reset cycle.
  assign ion   = (state == IGNT) && !RST;
  assign don   = (state == DGNT) && !RST;
  assign icomp = ion && ireq && acc;
  assign dcomp = don && dreq && acc;

  assign iwait = ~icomp;
  assign dwait = ~dcomp;
  assign iload = ramload;
  assign dload = ramload;

  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    if (don) begin
      ramREN   = dREN & ~dWEN;
      ramWEN   = dWEN;
      ramaddr  = daddr;
      ramstore = dstore;
    end else if (ion) begin
      ramREN  = iREN;
      ramaddr = iaddr;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      last_d   <= 1'b0;
      hold_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          hold_cnt <= '0;
          if (dreq && (!ireq || !last_d)) state <= DGNT;
          else if (ireq) state <= IGNT;
        end
        DGNT: begin
          if (!ireq) hold_cnt <= '0;
          else if (hold_cnt < HW'(LOCK_MAX)) hold_cnt <= hold_cnt + 1'b1;
          // Burst lock: stay granted between words unless icache timed out.
          if (!dreq) state <= IDLE;
          else if (acc) begin
            last_d <= 1'b1;
            if (ireq && hold_cnt >= HW'(LOCK_MAX - 1)) state <= IGNT;
          end
        end
        IGNT: begin
          hold_cnt <= '0;
          if (!ireq) state <= IDLE;
          else if (acc) begin
            last_d <= 1'b0;
            state  <= dreq ? DGNT : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ARB_STATS_EN
  logic err;
  assign err = ((ion && ireq) || (don && dreq)) && (ramstate == 2'd3);

  always_ff @(posedge CLK) begin
    if (RST) begin
      icnt <= '0;
      dcnt <= '0;
      ecnt <= '0;
    end else begin
      if (icomp && !(&icnt)) icnt <= icnt + 1'b1;
      if (dcomp && !(&dcnt)) dcnt <= dcnt + 1'b1;
      if (err && !(&ecnt)) ecnt <= ecnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb_cache_mem_arbiter: directed and random checks of cache_mem_arbiter
// against a cycle-level ownership model of the shared RAM port.
module tb_cache_mem_arbiter;

  localparam int LOCK_MAX = 16;
  localparam int CNT_W = 16;
  localparam int CMAX = (1 << CNT_W) - 1;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        iREN = 1'b0;
  logic [31:0] iaddr = '0;
  logic        iwait;
  logic [31:0] iload;
  logic        dREN = 1'b0;
  logic        dWEN = 1'b0;
  logic [31:0] daddr = '0;
  logic [31:0] dstore = '0;
  logic        dwait;
  logic [31:0] dload;
  logic        ramREN, ramWEN;
  logic [31:0] ramaddr, ramstore;
  logic [31:0] ramload = '0;
  logic [1:0]  ramstate = 2'd0;
`ifdef ARB_STATS_EN
  logic [CNT_W-1:0] icnt, dcnt, ecnt;
`endif

  cache_mem_arbiter #(
    .LOCK_MAX(LOCK_MAX)
`ifdef ARB_STATS_EN
    , .CNT_W(CNT_W)
`endif
  ) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
    .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate)
`ifdef ARB_STATS_EN
    , .icnt(icnt), .dcnt(dcnt), .ecnt(ecnt)
`endif
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Model: who owns the RAM port (0 none, 1 icache, 2 dcache).
  int m_own = 0;
  int m_last = 1;
  int m_wait = 0;
  int m_ic = 0, m_dc = 0, m_ec = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    logic        e_ren, e_wen, e_iw, e_dw;
    logic [31:0] e_a, e_s;
    bit acc;
    int own;
    acc = (ramstate == 2'd2);
    own = RST ? 0 : m_own;
    e_ren = 0; e_wen = 0; e_iw = 1; e_dw = 1; e_a = 0; e_s = 0;
    if (own == 2) begin
      e_wen = dWEN;
      e_ren = dREN && !dWEN;
      e_a = daddr;
      e_s = dstore;
      e_dw = !((dREN || dWEN) && acc);
    end else if (own == 1) begin
      e_ren = iREN;
      e_a = iaddr;
      e_iw = !(iREN && acc);
    end
    chk("m_ramREN", ramREN, e_ren);
    chk("m_ramWEN", ramWEN, e_wen);
    chk("m_ramaddr", ramaddr, e_a);
    chk("m_ramstore", ramstore, e_s);
    chk("m_iwait", iwait, e_iw);
    chk("m_dwait", dwait, e_dw);
    chk("m_iload", iload, ramload);
    chk("m_dload", dload, ramload);
    chk("wait_excl", {31'b0, !iwait && !dwait}, 32'd0);
`ifdef ARB_STATS_EN
    chk("m_icnt", icnt, m_ic);
    chk("m_dcnt", dcnt, m_dc);
    chk("m_ecnt", ecnt, m_ec);
`endif
  endtask

  task automatic model_next();
    bit ir, dr, acc;
    int own, last, w;
    ir = iREN;
    dr = dREN || dWEN;
    acc = (ramstate == 2'd2);
    own = m_own; last = m_last; w = 0;
    if (RST) begin
      own = 0; last = 1;
      m_ic = 0; m_dc = 0; m_ec = 0;
    end else begin
      if (m_own == 1 && ir && acc && m_ic < CMAX) m_ic++;
      if (m_own == 2 && dr && acc && m_dc < CMAX) m_dc++;
      if (((m_own == 1 && ir) || (m_own == 2 && dr)) && ramstate == 2'd3
          && m_ec < CMAX) m_ec++;
      if (m_own == 0) begin
        if (dr && !(ir && m_last == 2)) own = 2;
        else if (ir) own = 1;
      end else if (m_own == 2) begin
        w = ir ? ((m_wait < LOCK_MAX) ? m_wait + 1 : m_wait) : 0;
        if (!dr) own = 0;
        else if (acc) begin
          last = 2;
          if (ir && m_wait >= LOCK_MAX - 1) own = 1;
        end
      end else begin
        if (!ir) own = 0;
        else if (acc) begin
          last = 1;
          own = dr ? 2 : 0;
        end
      end
    end
    m_own = own; m_last = last; m_wait = w;
  endtask

  // Called at a negedge with inputs set; leaves time at the next negedge.
  task automatic tick();
    #1;
    check_model();
    model_next();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic do_reset();
    iREN = 0; dREN = 0; dWEN = 0; ramstate = 2'd0;
    RST = 1;
    tick();
    tick();
    RST = 0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_i, ndw, found, n;
    @(negedge CLK);

    // Reset state, then a single icache read
    do_reset();
    #1;
    chk("rst_ramREN", ramREN, 0);
    chk("rst_ramWEN", ramWEN, 0);
    chk("rst_ramaddr", ramaddr, 0);
    chk("rst_iwait", iwait, 1);
    chk("rst_dwait", dwait, 1);
    iREN = 1; iaddr = 32'h40; ramstate = 2'd2; ramload = 32'hdead0040;
    #1;
    chk("ireq_latency", ramREN, 0);
    tick();
    #1;
    chk("i_ramREN", ramREN, 1);
    chk("i_ramaddr", ramaddr, 32'h40);
    chk("i_iwait", iwait, 0);
    chk("i_iload", iload, 32'hdead0040);
    tick();
    #1;
    chk("i_one_word", iwait, 1);
    iREN = 0;
    tick();

    // Tie after reset: dcache wins, 2-word fill, then icache
    do_reset();
    iREN = 1; iaddr = 32'h44; dREN = 1; daddr = 32'h80; ramstate = 2'd2;
    tick();
    #1;
    chk("tie_d_addr0", ramaddr, 32'h80);
    chk("tie_d_dwait0", dwait, 0);
    chk("tie_d_iwait0", iwait, 1);
    tick();
    daddr = 32'h84;
    #1;
    chk("tie_d_addr1", ramaddr, 32'h84);
    chk("tie_d_dwait1", dwait, 0);
    tick();
    dREN = 0;
    found = 0;
    for (int k = 0; k < 10 && found == 0; k++) begin
      #1;
      if (!iwait) found = 1;
      tick();
    end
    chk("tie_i_after_burst", found, 1);
    iREN = 0;
    tick();

    // Burst lock and icache timeout
    do_reset();
    iREN = 1; dREN = 1; daddr = 32'h200; iaddr = 32'h300;
    first_i = -1; ndw = 0;
    for (int t = 0; t < 40; t++) begin
      ramstate = (t % 2 == 1) ? 2'd2 : 2'd1;
      #1;
      if (!iwait && first_i < 0) first_i = t;
      if (!dwait && first_i < 0) ndw++;
      tick();
    end
    chk("lock_i_cycle", first_i, 19);
    chk("lock_d_words", ndw, 9);
    iREN = 0; dREN = 0;
    tick();

    // Write wins when dREN and dWEN are both high
    do_reset();
    dREN = 1; dWEN = 1; daddr = 32'h3100; dstore = 32'h5; ramstate = 2'd1;
    tick();
    #1;
    chk("wr_ramWEN", ramWEN, 1);
    chk("wr_ramREN", ramREN, 0);
    chk("wr_ramstore", ramstore, 32'h5);
    chk("wr_ramaddr", ramaddr, 32'h3100);
    chk("wr_busy_dwait", dwait, 1);
    tick();
    ramstate = 2'd2;
    #1;
    chk("wr_acc_dwait", dwait, 0);
    tick();
    dREN = 0; dWEN = 0;
    tick();
    tick();

    // Abort by withdrawing dREN mid-BUSY
    do_reset();
    dREN = 1; daddr = 32'h500; ramstate = 2'd1;
    tick();
    #1;
    chk("ab_granted", ramREN, 1);
    tick();
    dREN = 0;
    #1;
    chk("ab_drop_same", ramREN, 0);
    tick();
    iREN = 1; iaddr = 32'h600; ramstate = 2'd2;
    #1;
    chk("ab_idle", ramREN, 0);
    tick();
    #1;
    chk("ab_i_ren", ramREN, 1);
    chk("ab_i_addr", ramaddr, 32'h600);
    iREN = 0;
    tick();
    tick();

    // Abort by reset during DGNT
    dREN = 1; daddr = 32'h540; ramstate = 2'd1;
    tick();
    #1;
    chk("rab_granted", ramREN, 1);
    RST = 1;
    #1;
    chk("rab_drop", ramREN, 0);
    tick();
    RST = 0; dREN = 0; iREN = 1; iaddr = 32'h700; ramstate = 2'd2;
    #1;
    chk("rab_idle", ramREN, 0);
    tick();
    #1;
    chk("rab_i_ren", ramREN, 1);
    chk("rab_i_addr", ramaddr, 32'h700);
    iREN = 0;
    tick();

    // Randomized traffic against the model
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 3) == 0) iREN = ~iREN;
      if ($urandom_range(0, 3) == 0) dREN = ~dREN;
      if ($urandom_range(0, 5) == 0) dWEN = ~dWEN;
      iaddr = $urandom;
      daddr = $urandom;
      dstore = $urandom;
      ramload = $urandom;
      ramstate = 2'($urandom_range(0, 3));
      RST = ($urandom_range(0, 199) == 0);
      tick();
    end
    RST = 0;

`ifdef ARB_STATS_EN
    do_reset();
    #1;
    chk("st_rst_icnt", icnt, 0);
    chk("st_rst_dcnt", dcnt, 0);
    chk("st_rst_ecnt", ecnt, 0);
    dREN = 1; daddr = 32'h900;
    for (int t = 0; t < 7; t++) begin
      case (t)
        0: ramstate = 2'd0;
        1, 3: ramstate = 2'd3;
        default: ramstate = 2'd2;
      endcase
      tick();
    end
    dREN = 0; ramstate = 2'd0;
    tick();
    iREN = 1; iaddr = 32'ha00; ramstate = 2'd2;
    n = 0;
    for (int k = 0; k < 20 && n < 3; k++) begin
      #1;
      if (!iwait) n++;
      tick();
    end
    iREN = 0;
    tick();
    #1;
    chk("st_icnt", icnt, 3);
    chk("st_dcnt", dcnt, 4);
    chk("st_ecnt", ecnt, 2);
    RST = 1;
    tick();
    RST = 0;
    #1;
    chk("st_clr_icnt", icnt, 0);
    chk("st_clr_dcnt", dcnt, 0);
    chk("st_clr_ecnt", ecnt, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
- Sequences the single shared RAM port between the instruction cache (read-only) and the data cache (read/write, two-word block fills and writebacks).
- Sits between the cache pair and RAM, in place of a direct cache-to-RAM connection.
- Uses registered grants, round-robin on ties, and burst locking so dcache block transfers are not split.
- A lock timeout bounds how long icache can be starved.

Parameters:
- LOCK_MAX, 16: maximum consecutive cycles dcache may hold the grant while icache is pending.
- CNT_W, 16: width of the statistics counters (used only with ARB_STATS_EN).

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  synchronous, active-high reset.
- iREN  in  1  icache read request.
- iaddr  in  32  icache word address.
- iwait  out  1  low for exactly the cycle the icache word completes.
- iload  out  32  icache read data; equals ramload.
- dREN  in  1  dcache read request.
- dWEN  in  1  dcache write request.
- daddr  in  32  dcache word address.
- dstore  in  32  dcache write data.
- dwait  out  1  low for exactly the cycle the dcache word completes.
- dload  out  32  dcache read data; equals ramload.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data.
- ramstate  in  2  RAM status: FREE=0, BUSY=1, ACCESS=2, ERROR=3.

Behaviour:
- Reset:
  - State IDLE; last_grant=I, so dcache wins the first tie.
  - hold_cnt=0.
  - ramREN=ramWEN=0; ramaddr=ramstore=0; iwait=dwait=1.
- Request definitions: ireq=iREN; dreq=dREN|dWEN.
  - If dREN and dWEN are both high, the access is a write (ramWEN=1, ramREN=0).
- Word completion: the cycle the granted requester is driving and ramstate==ACCESS.
  - BUSY, FREE and ERROR are not completion; the requester keeps waiting.
  - ERROR is held off until RAM returns ACCESS.
- IDLE:
  - RAM outputs are deasserted and both wait outputs are 1.
  - dreq only -> DGNT. ireq only -> IGNT.
  - Both pending -> grant the requester not equal to last_grant.
  - Grant takes effect the next cycle (1-cycle arbitration latency).
- DGNT:
  - ramaddr=daddr, ramstore=dstore, ramREN/ramWEN from dREN/dWEN. All are combinational, gated by the grant.
  - dwait=~completion; iwait=1.
  - hold_cnt increments each cycle while ireq=1; otherwise it clears.
  - On completion, in priority order:
    1. dreq falls the next cycle -> IDLE, last_grant=D.
    2. ireq && hold_cnt>=LOCK_MAX-1 -> IGNT, last_grant=D.
    3. Otherwise stay in DGNT (burst lock; covers WB0/WB1/MEM0/MEM1 sequences).
  - If dreq drops without completion -> IDLE; RAM enables fall in the same cycle (combinational gating).
- IGNT:
  - ramaddr=iaddr, ramREN=1, ramWEN=0; iwait=~completion; dwait=1.
  - On completion: dreq -> DGNT, else IDLE; last_grant=I; hold_cnt=0.
  - Only one word per icache grant.
  - If iREN drops mid-transfer -> IDLE.
- The grant never changes while a word is incomplete, except when the requester withdraws.
- Both wait outputs are never low in the same cycle.
- hold_cnt saturates at LOCK_MAX.
- RST asserted mid-transfer: the next edge returns to the reset values. RAM enables drop that cycle; the RAM side is expected to abort.

Optional Feature:
- Macro ARB_STATS_EN.
- When defined, adds three outputs:
  - icnt (CNT_W): completed icache words.
  - dcnt (CNT_W): completed dcache words.
  - ecnt (CNT_W): cycles with ramstate==ERROR while granted.
- All three are saturating, cleared by RST, and updated on the completion edge.
- When undefined, these ports and their counters are absent, and behaviour is otherwise identical.

Test Plan:
- Reset: RST=1 for 2 cycles, then iREN=1, iaddr=0x40 with ramstate=ACCESS every cycle -> ramREN=1 with ramaddr=0x40 on the cycle after the request; iwait low 1 cycle; iload=ramload.
- Tie after reset: iREN=dREN=1 together -> DGNT first; dcache two-word fill 0x80, 0x84 completes; IGNT next; iwait falls after the dcache burst.
- Burst lock and timeout: dREN held 40 cycles with ramstate=BUSY,ACCESS alternating and iREN=1 throughout -> grant passes to icache on the first dcache completion at or after 15 waiting cycles, never mid-word.
- Write priority: dREN=dWEN=1, daddr=0x3100, dstore=0x5 -> ramWEN=1, ramREN=0, ramstore=0x5; dwait low on ACCESS.
- Abort: dREN dropped mid-BUSY, and separately RST raised during DGNT -> RAM enables 0 the same/next cycle; state IDLE; a following iREN is granted in 1 cycle.
- ARB_STATS_EN: 3 icache words, 4 dcache words, 2 ERROR cycles -> icnt=3, dcnt=4, ecnt=2; RST clears all three.
